// File: rtl/rf_pkg.sv
// Shared widths and requester identifiers for the register-file write arbiter.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_CNT_W  = 8;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;

    typedef enum logic {
        GRANT_ALU  = 1'b0,
        GRANT_LOAD = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin decision; purely combinational.
module rr_arb2
    import rf_pkg::*;
(
    input  logic   valid0,
    input  logic   valid1,
    input  logic   hold,
    input  grant_e last_grant,
    output logic   grant0,
    output logic   grant1
);

    logic both;

    always_comb begin
        both   = valid0 && valid1;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!hold) begin
            if (both) begin
                // On contention the requester that did not win last time goes.
                grant0 = (last_grant == GRANT_LOAD);
                grant1 = (last_grant == GRANT_ALU);
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    logic              grant0, grant1;
    grant_e            last_grant_q, last_grant_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;

    // Folding reset into hold keeps both readies low while reset is asserted.
    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .hold       (hold || !reset_n),
        .last_grant (last_grant_q),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        last_grant_d = last_grant_q;
        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (grant0) begin
            last_grant_d = GRANT_ALU;
            regwrite_d   = 1'b1;
            write_reg_d  = req0_addr;
            write_data_d = req0_data;
            if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
        end else if (grant1) begin
            last_grant_d = GRANT_LOAD;
            regwrite_d   = 1'b1;
            write_reg_d  = req1_addr;
            write_data_d = req1_data;
            if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= GRANT_LOAD;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign RegWrite   = regwrite_q;
    assign WriteReg   = write_reg_q;
    assign WriteData  = write_data_q;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; inputs change and outputs are sampled around negedge.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          hold = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready, RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    int chk_cnt = 0;
    int pass_cnt = 0;

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .hold(hold),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0; hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #12;
        chk_cnt++; if (RegWrite !== 1'b0) $display("FAIL rst_regwrite: got %b want 0", RegWrite); else pass_cnt++;
        chk_cnt++; if (WriteReg !== 5'd0) $display("FAIL rst_writereg: got %0d want 0", WriteReg); else pass_cnt++;
        chk_cnt++; if (WriteData !== 32'd0) $display("FAIL rst_writedata: got %0h want 0", WriteData); else pass_cnt++;
        chk_cnt++; if (grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0) $display("FAIL rst_cnt: got %0d/%0d want 0/0", grant_cnt0, grant_cnt1); else pass_cnt++;
        chk_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL rst_ready: got %b%b want 00", req0_ready, req1_ready); else pass_cnt++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clock);
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h55;
        #1;
        chk_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready); else pass_cnt++;
        @(negedge clock);
        req0_valid = 1'b0;
        #1;
        chk_cnt++; if (RegWrite !== 1'b1) $display("FAIL single_regwrite: got %b want 1", RegWrite); else pass_cnt++;
        chk_cnt++; if (WriteReg !== 5'd3 || WriteData !== 32'h55) $display("FAIL single_write: got %0d/%0h want 3/55", WriteReg, WriteData); else pass_cnt++;
        chk_cnt++; if (grant_cnt0 !== 8'd1) $display("FAIL single_cnt0: got %0d want 1", grant_cnt0); else pass_cnt++;
        @(negedge clock);
        #1;
        chk_cnt++; if (RegWrite !== 1'b0 || WriteReg !== 5'd3) $display("FAIL single_idle: got %b/%0d want 0/3", RegWrite, WriteReg); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic          exp0;
        logic [AW-1:0] exp_reg;
        do_reset();
        @(negedge clock);
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h10;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h20;
        for (int i = 0; i < 4; i++) begin
            exp0    = (i % 2 == 0);
            exp_reg = exp0 ? 5'd1 : 5'd2;
            #1;
            chk_cnt++; if (req0_ready !== exp0 || req1_ready !== !exp0) $display("FAIL rr_ready[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready, exp0, !exp0); else pass_cnt++;
            @(negedge clock);
            #1;
            chk_cnt++; if (RegWrite !== 1'b1 || WriteReg !== exp_reg) $display("FAIL rr_write[%0d]: got %b/%0d want 1/%0d", i, RegWrite, WriteReg, exp_reg); else pass_cnt++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk_cnt++; if (grant_cnt0 !== 8'd2 || grant_cnt1 !== 8'd2) $display("FAIL rr_cnt: got %0d/%0d want 2/2", grant_cnt0, grant_cnt1); else pass_cnt++;
    endtask

    task automatic test_hold();
        @(negedge clock);
        hold = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready); else pass_cnt++;
            @(negedge clock);
            #1;
            chk_cnt++; if (RegWrite !== 1'b0) $display("FAIL hold_regwrite[%0d]: got %b want 0", i, RegWrite); else pass_cnt++;
        end
        hold = 1'b0;
        #1;
        chk_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL hold_release: got %b%b want 10", req0_ready, req1_ready); else pass_cnt++;
        @(negedge clock);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk_cnt++; if (RegWrite !== 1'b1 || WriteReg !== 5'd1) $display("FAIL hold_write: got %b/%0d want 1/1", RegWrite, WriteReg); else pass_cnt++;
    endtask

    task automatic test_same_addr();
        @(negedge clock);
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hA;
        #1;
        chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL same_ready0: got %b want 1", req0_ready); else pass_cnt++;
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'hB;
        #1;
        chk_cnt++; if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'hA) $display("FAIL same_first: got %b/%0d/%0h want 1/5/a", RegWrite, WriteReg, WriteData); else pass_cnt++;
        chk_cnt++; if (req1_ready !== 1'b1) $display("FAIL same_ready1: got %b want 1", req1_ready); else pass_cnt++;
        @(negedge clock);
        req1_valid = 1'b0;
        #1;
        chk_cnt++; if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'hB) $display("FAIL same_second: got %b/%0d/%0h want 1/5/b", RegWrite, WriteReg, WriteData); else pass_cnt++;
        @(negedge clock);
        #1;
        chk_cnt++; if (RegWrite !== 1'b0 || WriteData !== 32'hB) $display("FAIL same_final: got %b/%0h want 0/b", RegWrite, WriteData); else pass_cnt++;
    endtask

    task automatic test_saturation();
        int miss = 0;
        do_reset();
        @(negedge clock);
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h1;
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hCAFE;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (req1_ready !== 1'b1 || RegWrite !== 1'b1) miss++;
            if (i == 200) begin
                chk_cnt++; if (grant_cnt1 !== 8'd200) $display("FAIL sat_mid_cnt1: got %0d want 200", grant_cnt1); else pass_cnt++;
            end
            @(negedge clock);
        end
        req1_valid = 1'b0;
        #1;
        chk_cnt++; if (miss !== 0) $display("FAIL sat_bubbles: got %0d idle cycles want 0", miss); else pass_cnt++;
        chk_cnt++; if (grant_cnt1 !== 8'd255) $display("FAIL sat_cnt1: got %0d want 255", grant_cnt1); else pass_cnt++;
        chk_cnt++; if (grant_cnt0 !== 8'd1) $display("FAIL sat_cnt0: got %0d want 1", grant_cnt0); else pass_cnt++;
        chk_cnt++; if (RegWrite !== 1'b1 || WriteReg !== 5'd0 || WriteData !== 32'hCAFE) $display("FAIL sat_reg0_write: got %b/%0d/%0h want 1/0/cafe", RegWrite, WriteReg, WriteData); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
        @(negedge clock);
        #1;
        chk_cnt++; if (RegWrite !== 1'b1 || WriteReg !== 5'd9) $display("FAIL arst_pre: got %b/%0d want 1/9", RegWrite, WriteReg); else pass_cnt++;
        #1 reset_n = 1'b0;
        #1;
        chk_cnt++; if (RegWrite !== 1'b0 || WriteReg !== 5'd0 || WriteData !== 32'd0) $display("FAIL arst_outputs: got %b/%0d/%0h want 0/0/0", RegWrite, WriteReg, WriteData); else pass_cnt++;
        chk_cnt++; if (grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0) $display("FAIL arst_cnt: got %0d/%0d want 0/0", grant_cnt0, grant_cnt1); else pass_cnt++;
        chk_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL arst_ready: got %b%b want 00", req0_ready, req1_ready); else pass_cnt++;
        @(negedge clock);
        #1;
        chk_cnt++; if (RegWrite !== 1'b0 || grant_cnt0 !== 8'd0) $display("FAIL arst_held: got %b/%0d want 0/0", RegWrite, grant_cnt0); else pass_cnt++;
        reset_n = 1'b1;
        #1;
        chk_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL arst_first_contention: got %b%b want 10", req0_ready, req1_ready); else pass_cnt++;
        @(negedge clock);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk_cnt++; if (RegWrite !== 1'b1 || WriteReg !== 5'd9 || grant_cnt0 !== 8'd1) $display("FAIL arst_after: got %b/%0d/%0d want 1/9/1", RegWrite, WriteReg, grant_cnt0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_same_addr();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

endmodule
